// File: rtl/bcd_scan_mux.sv
// Four-digit time-multiplexed scan driver for a common-anode 7-segment display.
// Holds a packed BCD value, scans digits 3..0 one slot at a time onto the
// {A,B,C,D} nibble bus and drives the active-low digit anode enables.
// New values and the blanking mode are committed only at frame boundaries.
// The frame boundary is the end of digit 0's slot, so updates never tear a frame.
module bcd_scan_mux #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic [3:0]  dig_an,
  output logic        frame_done,
  output logic        pending
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);

  // A slot needs a guard cycle plus at least one lit cycle.
  if (PRESCALE < 2) begin : gen_bad_prescale
    $error("bcd_scan_mux: PRESCALE must be at least 2");
  end

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     disp_q, disp_d;
  logic [15:0]     pend_q, pend_d;
  logic            lz_q, lz_d;
  logic            pending_q, pending_d;

  logic            slot_end;
  logic            wrap;
  logic [3:0]      blank;
  logic [3:0]      digit;
  logic [3:0]      nibble;

  assign slot_end = (cnt_q == CntLast);
  // Wrap edge: last cycle of digit 0's slot, i.e. the last cycle of the frame.
  assign wrap     = slot_end && (idx_q == 2'd0);

  // Slot counter and digit index; idx naturally wraps 0 -> 3 on decrement.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q - 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Shadow/display update: loads park in the shadow register until the wrap,
  // except a load on the wrap edge itself, which goes straight to the display.
  always_comb begin
    disp_d    = disp_q;
    pend_d    = pend_q;
    lz_d      = lz_q;
    pending_d = pending_q;
    if (wrap) begin
      lz_d      = blank_lz;
      pending_d = 1'b0;
      if (load) begin
        disp_d = bcd_in;
        pend_d = bcd_in;
      end else if (pending_q) begin
        disp_d = pend_q;
      end
    end else if (load) begin
      pend_d    = bcd_in;
      pending_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= 2'd3;
      disp_q    <= 16'h0000;
      pend_q    <= 16'h0000;
      lz_q      <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      lz_q      <= lz_d;
      pending_q <= pending_d;
    end
  end

  // Leading-zero blank mask: digit i is blank when it and all higher digits are zero.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = lz_q && (disp_q[15:12] == 4'h0);
    blank[2] = lz_q && (disp_q[15:8] == 8'h00);
    blank[1] = lz_q && (disp_q[15:4] == 12'h000);
  end

  // Select the digit for the current slot; invalid codes pass through untouched.
  always_comb begin
    digit = disp_q[3:0];
    case (idx_q)
      2'd3:    digit = disp_q[15:12];
      2'd2:    digit = disp_q[11:8];
      2'd1:    digit = disp_q[7:4];
      default: digit = disp_q[3:0];
    endcase
    // 4'hF makes the downstream decoder turn every segment off.
    nibble = blank[idx_q] ? 4'hF : digit;
  end

  // Outputs decode from registers only; guard cycle keeps all anodes off.
  always_comb begin
    {A, B, C, D} = nibble;
    dig_an       = (cnt_q == '0) ? 4'b1111 : ~(4'b0001 << idx_q);
    frame_done   = wrap;
    pending      = pending_q;
  end

endmodule
